// File: rtl/bank_isu_sched.sv
// Bank issue scheduler: an in-order issue queue whose head is released to
// the SC only when its linefill (if any) has returned and the target xbar
// channel holds a credit. Each channel also stamps a rolling ROB id.
module bank_isu_sched #(
    parameter int  DEPTH       = 8,
    parameter int  NUM_CH      = 3,
    parameter int  CREDIT_INIT = 4,
    parameter int  LF_ID_W     = 6,
    parameter int  ROB_W       = 3,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CREDIT_W    = $clog2(CREDIT_INIT + 1),
    localparam int PTR_W       = $clog2(DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,

    // Request push from the HTU
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [CH_W-1:0]     req_ch_id_i,
    input  logic [2:0]          req_opcode_i,
    input  logic [6:0]          req_set_way_offset_i,
    input  logic                req_need_linefill_i,
    input  logic [LF_ID_W-1:0]  req_lf_id_i,

    // Linefill data return from the BIU (always accepted)
    input  logic                biu_rvalid_i,
    input  logic [LF_ID_W-1:0]  biu_rid_i,

    // Issue to the SC
    output logic                isu_sc_valid_o,
    input  logic                isu_sc_ready_i,
    output logic [CH_W-1:0]     isu_sc_channel_id_o,
    output logic [2:0]          isu_sc_opcode_o,
    output logic [6:0]          isu_sc_set_way_offset_o,
    output logic                isu_sc_linefill_o,
    output logic [ROB_W-1:0]    isu_sc_rob_id_o,

    // Credit return pulses from the xbar
    input  logic [NUM_CH-1:0]   xbar_credit_ret_i,

    output logic                credit_err_o,
    output logic [PTR_W-1:0]    iq_count_o
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int NUM_LF = 1 << LF_ID_W;

    typedef struct packed {
        logic [CH_W-1:0]    ch;
        logic [2:0]         opcode;
        logic [6:0]         set_way_offset;
        logic               linefill;
        logic [LF_ID_W-1:0] lf_id;
    } entry_t;

    entry_t               entries [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [NUM_LF-1:0]    inflight;
    logic [CREDIT_W-1:0]  credit [NUM_CH];
    logic [ROB_W-1:0]     rob_id [NUM_CH];
    logic                 credit_err;

    entry_t               new_entry;
    entry_t               head;
    logic                 empty;
    logic                 full;
    logic                 blocked;
    logic                 push;
    logic                 issue;
    logic [CREDIT_W-1:0]  head_credit;
    logic [ROB_W-1:0]     head_rob;
    logic [NUM_CH-1:0]    issue_ch;

    // Queue status: the extra pointer bit separates full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                     (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign head    = entries[rd_ptr[IDX_W-1:0]];
    assign blocked = head.linefill && inflight[head.lf_id];

    assign new_entry = '{
        ch:             req_ch_id_i,
        opcode:         req_opcode_i,
        set_way_offset: req_set_way_offset_i,
        linefill:       req_need_linefill_i,
        lf_id:          req_lf_id_i
    };

    // Head channel lookup; a channel id outside NUM_CH matches nothing and
    // therefore reads as zero credit, so such a head never issues.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        head_credit = '0;
        head_rob    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (head.ch == CH_W'(c)) begin
                head_credit = credit[c];
                head_rob    = rob_id[c];
            end
        end
    end

    assign push           = req_valid_i && !full;
    assign isu_sc_valid_o = !empty && !blocked && (head_credit != '0);
    assign issue          = isu_sc_valid_o && isu_sc_ready_i;

    // One-hot of the channel that issues this cycle.
    always_comb begin
        issue_ch = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            issue_ch[c] = issue && (head.ch == CH_W'(c));
        end
    end

    assign req_ready_o             = !full;
    assign isu_sc_channel_id_o     = head.ch;
    assign isu_sc_opcode_o         = head.opcode;
    assign isu_sc_set_way_offset_o = head.set_way_offset;
    assign isu_sc_linefill_o       = head.linefill;
    assign isu_sc_rob_id_o         = head_rob;
    assign credit_err_o            = credit_err;
    assign iq_count_o              = wr_ptr - rd_ptr;

    // Entry storage write on an accepted push.
    // NOTE: storage has no reset; only slots between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            entries[wr_ptr[IDX_W-1:0]] <= new_entry;
        end
    end

    // Read/write pointers; wrap at DEPTH falls out of the power-of-2 width.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // In-flight linefill bitmap; the set is written last so it wins over a
    // same-cycle clear of the same id.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight <= '0;
        end else begin
            if (biu_rvalid_i) begin
                inflight[biu_rid_i] <= 1'b0;
            end
            if (push && req_need_linefill_i) begin
                inflight[req_lf_id_i] <= 1'b1;
            end
        end
    end

    // Per-channel credits, ROB ids and the sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                credit[c] <= CREDIT_W'(CREDIT_INIT);
                rob_id[c] <= '0;
            end
            credit_err <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (issue_ch[c]) begin
                    rob_id[c] <= rob_id[c] + ROB_W'(1);
                end
                if (issue_ch[c] && !xbar_credit_ret_i[c]) begin
                    credit[c] <= credit[c] - CREDIT_W'(1);
                end else if (!issue_ch[c] && xbar_credit_ret_i[c]) begin
                    if (credit[c] == CREDIT_W'(CREDIT_INIT)) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit[c] <= credit[c] + CREDIT_W'(1);
                    end
                end
            end
        end
    end

    // Occupancy can never exceed the queue size.
    assert property (@(posedge clk_i) disable iff (rst_i) iq_count_o <= PTR_W'(DEPTH));

endmodule

// File: tb/tb_bank_isu_sched.sv
// Self-checking bench for bank_isu_sched: directed scenarios plus random
// traffic, scored against a queue-based behavioural model.
module tb_bank_isu_sched;

    localparam int DEPTH       = 8;
    localparam int NUM_CH      = 3;
    localparam int CREDIT_INIT = 4;
    localparam int LF_ID_W     = 6;
    localparam int ROB_W       = 3;
    localparam int CH_W        = 2;
    localparam int PTR_W       = 4;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [CH_W-1:0]     req_ch_id_i;
    logic [2:0]          req_opcode_i;
    logic [6:0]          req_set_way_offset_i;
    logic                req_need_linefill_i;
    logic [LF_ID_W-1:0]  req_lf_id_i;
    logic                biu_rvalid_i;
    logic [LF_ID_W-1:0]  biu_rid_i;
    logic                isu_sc_valid_o;
    logic                isu_sc_ready_i;
    logic [CH_W-1:0]     isu_sc_channel_id_o;
    logic [2:0]          isu_sc_opcode_o;
    logic [6:0]          isu_sc_set_way_offset_o;
    logic                isu_sc_linefill_o;
    logic [ROB_W-1:0]    isu_sc_rob_id_o;
    logic [NUM_CH-1:0]   xbar_credit_ret_i;
    logic                credit_err_o;
    logic [PTR_W-1:0]    iq_count_o;

    always #5 clk_i = ~clk_i;

    bank_isu_sched #(
        .DEPTH(DEPTH), .NUM_CH(NUM_CH), .CREDIT_INIT(CREDIT_INIT),
        .LF_ID_W(LF_ID_W), .ROB_W(ROB_W)
    ) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .req_valid_i             (req_valid_i),
        .req_ready_o             (req_ready_o),
        .req_ch_id_i             (req_ch_id_i),
        .req_opcode_i            (req_opcode_i),
        .req_set_way_offset_i    (req_set_way_offset_i),
        .req_need_linefill_i     (req_need_linefill_i),
        .req_lf_id_i             (req_lf_id_i),
        .biu_rvalid_i            (biu_rvalid_i),
        .biu_rid_i               (biu_rid_i),
        .isu_sc_valid_o          (isu_sc_valid_o),
        .isu_sc_ready_i          (isu_sc_ready_i),
        .isu_sc_channel_id_o     (isu_sc_channel_id_o),
        .isu_sc_opcode_o         (isu_sc_opcode_o),
        .isu_sc_set_way_offset_o (isu_sc_set_way_offset_o),
        .isu_sc_linefill_o       (isu_sc_linefill_o),
        .isu_sc_rob_id_o         (isu_sc_rob_id_o),
        .xbar_credit_ret_i       (xbar_credit_ret_i),
        .credit_err_o            (credit_err_o),
        .iq_count_o              (iq_count_o)
    );

    typedef struct {
        int ch;
        int op;
        int swo;
        int lf;
        int lf_id;
        int rob;
    } exp_t;

    exp_t exp_q[$];        // requests accepted and not yet issued, oldest first
    int   issued_rob[$];   // ROB ids seen at issue, for directed sequences
    int   push_rob [4];    // ROB id the next push on each channel will carry
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the accepted request is recorded after the edge.
    task automatic step(input bit v, input int ch, input bit nlf, input int lfid,
                        input bit rdy, input int ret, input bit bv, input int brid,
                        input bit rst);
        bit   accept;
        exp_t e;
        rst_i                = rst;
        req_valid_i          = v;
        req_ch_id_i          = CH_W'(ch);
        req_opcode_i         = 3'($urandom_range(0, 7));
        req_set_way_offset_i = 7'($urandom_range(0, 127));
        req_need_linefill_i  = nlf;
        req_lf_id_i          = LF_ID_W'(lfid);
        isu_sc_ready_i       = rdy;
        xbar_credit_ret_i    = NUM_CH'(ret);
        biu_rvalid_i         = bv;
        biu_rid_i            = LF_ID_W'(brid);
        accept = v && !rst && (exp_q.size() < DEPTH);
        e.ch    = ch;
        e.op    = int'(req_opcode_i);
        e.swo   = int'(req_set_way_offset_i);
        e.lf    = int'(nlf);
        e.lf_id = lfid;
        e.rob   = 0;
        @(posedge clk_i);
        #1;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) push_rob[i] = 0;
        end else if (accept) begin
            e.rob        = push_rob[ch];
            push_rob[ch] = (push_rob[ch] + 1) % (1 << ROB_W);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input bit rdy, input int ret);
        step(0, 0, 0, 0, rdy, ret, 0, 0, 0);
    endtask

    task automatic push_req(input int ch, input bit rdy, input int ret);
        step(1, ch, 0, 0, rdy, ret, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Issue everything outstanding, releasing the head's linefill and credits.
    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step(0, 0, 0, 0, 1, $urandom_range(0, 7), 1, exp_q[0].lf_id, 0);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor and reference model. At each falling edge the model holds the
    // state after the preceding rising edge; it checks the DUT outputs, then
    // advances itself using the inputs that the next rising edge will see.
    bit   model_live = 1'b0;
    bit   inflight_m [1 << LF_ID_W];
    int   credit_m   [NUM_CH];
    bit   err_m;

    task automatic model_reset();
        for (int i = 0; i < (1 << LF_ID_W); i++) inflight_m[i] = 1'b0;
        for (int c = 0; c < NUM_CH; c++) credit_m[c] = CREDIT_INIT;
        err_m = 1'b0;
    endtask

    always @(negedge clk_i) begin : monitor
        exp_t h;
        bit   vexp;
        bit   acc;
        bit   iss;
        bit   iss_c;
        if (model_live) begin
            vexp = 1'b0;
            h    = '{default: 0};
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                if (!(h.lf != 0 && inflight_m[h.lf_id]) && h.ch < NUM_CH) begin
                    vexp = (credit_m[h.ch] != 0);
                end
            end
            check("iq_count",   int'(iq_count_o),     exp_q.size());
            check("req_ready",  int'(req_ready_o),    int'(exp_q.size() < DEPTH));
            check("isu_valid",  int'(isu_sc_valid_o), int'(vexp));
            check("credit_err", int'(credit_err_o),   int'(err_m));
            if (vexp && isu_sc_valid_o) begin
                check("sc_channel", int'(isu_sc_channel_id_o),     h.ch);
                check("sc_opcode",  int'(isu_sc_opcode_o),         h.op);
                check("sc_swo",     int'(isu_sc_set_way_offset_o), h.swo);
                check("sc_lf",      int'(isu_sc_linefill_o),       h.lf);
                check("sc_rob",     int'(isu_sc_rob_id_o),         h.rob);
            end
            iss = vexp && isu_sc_ready_i && !rst_i;
            if (rst_i) begin
                model_reset();
            end else begin
                acc = req_valid_i && (exp_q.size() < DEPTH);
                if (biu_rvalid_i) inflight_m[biu_rid_i] = 1'b0;
                if (acc && req_need_linefill_i) inflight_m[req_lf_id_i] = 1'b1;
                for (int c = 0; c < NUM_CH; c++) begin
                    iss_c = iss && (h.ch == c);
                    if (iss_c && !xbar_credit_ret_i[c]) begin
                        credit_m[c]--;
                    end else if (!iss_c && xbar_credit_ret_i[c]) begin
                        if (credit_m[c] == CREDIT_INIT) err_m = 1'b1;
                        else credit_m[c]++;
                    end
                end
                if (iss) begin
                    issued_rob.push_back(int'(isu_sc_rob_id_o));
                    void'(exp_q.pop_front());
                end
            end
        end else if (rst_i) begin
            model_reset();
            model_live = 1'b1;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        for (int i = 0; i < 4; i++) push_rob[i] = 0;
        do_reset();
        do_reset();
        check("rst_count", int'(iq_count_o), 0);
        check("rst_ready", int'(req_ready_o), 1);
        check("rst_valid", int'(isu_sc_valid_o), 0);
        check("rst_err",   int'(credit_err_o), 0);

        // Eight ch0 requests against four credits: four issue, four stay.
        issued_rob.delete();
        for (int i = 0; i < 8; i++) push_req(0, 1, 0);
        repeat (4) idle(1, 0);
        check("credit_stall_count", int'(iq_count_o), 4);
        check("credit_stall_valid", int'(isu_sc_valid_o), 0);
        check("credit_stall_issued", issued_rob.size(), 4);
        for (int i = 0; i < 4 && i < issued_rob.size(); i++)
            check($sformatf("credit_stall_rob%0d", i), issued_rob[i], i);
        drain();

        // Linefill-blocked head is released the cycle after the BIU return.
        do_reset();
        step(1, 1, 1, 'h15, 1, 0, 0, 0, 0);
        repeat (3) idle(1, 0);
        check("lf_blocked_valid", int'(isu_sc_valid_o), 0);
        step(0, 0, 0, 0, 0, 0, 1, 'h15, 0);
        check("lf_release_valid", int'(isu_sc_valid_o), 1);
        idle(1, 0);
        check("lf_issued_count", int'(iq_count_o), 0);

        // Fill to DEPTH, attempt one more, then pop one.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) push_req(i % NUM_CH, 0, 0);
        check("full_count", int'(iq_count_o), DEPTH);
        check("full_ready", int'(req_ready_o), 0);
        idle(1, 0);
        check("pop_ready", int'(req_ready_o), 1);
        check("pop_count", int'(iq_count_o), DEPTH - 1);
        drain();

        // Credit return on a full channel sets the sticky error and holds credit.
        do_reset();
        idle(0, 3'b100);
        check("overflow_err", int'(credit_err_o), 1);
        for (int i = 0; i < 5; i++) push_req(2, 1, 0);
        repeat (3) idle(1, 0);
        check("overflow_credit_count", int'(iq_count_o), 1);
        check("overflow_credit_valid", int'(isu_sc_valid_o), 0);
        check("overflow_err_sticky", int'(credit_err_o), 1);

        // Issue and return on the same channel in one cycle leaves credit alone.
        do_reset();
        push_req(0, 0, 0);
        idle(1, 3'b001);
        for (int i = 0; i < 5; i++) push_req(0, 1, 0);
        repeat (3) idle(1, 0);
        check("same_cycle_count", int'(iq_count_o), 1);
        check("same_cycle_err", int'(credit_err_o), 0);

        // ROB ids wrap modulo 2^ROB_W, then reset mid-stream.
        do_reset();
        issued_rob.delete();
        for (int i = 0; i < 9; i++) push_req(0, 1, 3'b001);
        repeat (3) idle(1, 3'b001);
        check("rob_wrap_issued", issued_rob.size(), 9);
        for (int i = 0; i < 9 && i < issued_rob.size(); i++)
            check($sformatf("rob_wrap_seq%0d", i), issued_rob[i], i % 8);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 7, 0, 0, 0, 0, 0);
        do_reset();
        check("midrst_count", int'(iq_count_o), 0);
        check("midrst_valid", int'(isu_sc_valid_o), 0);
        step(0, 0, 0, 0, 1, 0, 1, 7, 0);
        push_req(0, 1, 0);
        idle(1, 0);
        check("stale_rid_count", int'(iq_count_o), 0);

        // A head aimed at a non-existent channel never issues.
        do_reset();
        push_req(3, 1, 0);
        push_req(0, 1, 0);
        repeat (4) idle(1, 7);
        check("bad_ch_valid", int'(isu_sc_valid_o), 0);
        check("bad_ch_count", int'(iq_count_o), 2);
        do_reset();

        // Random traffic.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            step($urandom_range(0, 99) < 60,
                 $urandom_range(0, NUM_CH - 1),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3),
                 $urandom_range(0, 99) < 75,
                 (($urandom_range(0, 3) == 0) ? 1 : 0) |
                 (($urandom_range(0, 3) == 0) ? 2 : 0) |
                 (($urandom_range(0, 3) == 0) ? 4 : 0),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3),
                 $urandom_range(0, 399) == 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bank_isu_sched.md
BANK_ISU_SCHED -- requirements
Module: bank_isu_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, issue-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter NUM_CH, default 3, number of xbar channels (>=1); CH_W = max(1, clog2(NUM_CH)).
REQ-003 SHALL have parameter CREDIT_INIT, default 4, per-channel credit count after reset; CREDIT_W = clog2(CREDIT_INIT+1).
REQ-004 SHALL have parameter LF_ID_W, default 6, linefill id width ({set,way}); in-flight bitmap has 2^LF_ID_W bits.
REQ-005 SHALL have parameter ROB_W, default 3, per-channel ROB id width.
REQ-006 SHALL have ports as follows; clock and reset are listed first.
REQ-007 clk_i  in  1  single clock; all state on rising edge.
REQ-008 rst_i  in  1  reset, synchronous, active-high.
REQ-009 req_valid_i  in  1 / req_ready_o  out  1  HTU push handshake.
REQ-010 req_ch_id_i  in  CH_W / req_opcode_i  in  3 / req_set_way_offset_i  in  7  request payload.
REQ-011 req_need_linefill_i  in  1 / req_lf_id_i  in  LF_ID_W  request allocated a linefill with this id.
REQ-012 biu_rvalid_i  in  1 / biu_rid_i  in  LF_ID_W  linefill data returned for id (always accepted).
REQ-013 isu_sc_valid_o  out  1 / isu_sc_ready_i  in  1  issue handshake to SC.
REQ-014 isu_sc_channel_id_o  out  CH_W / isu_sc_opcode_o  out  3 / isu_sc_set_way_offset_o  out  7 / isu_sc_linefill_o  out  1  head payload.
REQ-015 isu_sc_rob_id_o  out  ROB_W  ROB id of issuing channel.
REQ-016 xbar_credit_ret_i  in  NUM_CH  one-cycle credit-return pulse per channel.
REQ-017 credit_err_o  out  1  sticky credit overflow flag; iq_count_o  out  clog2(DEPTH)+1  occupancy.

Function
REQ-018 Queue SHALL be circular FIFO, rd/wr pointers clog2(DEPTH)+1 bits, wrap at DEPTH.
REQ-019 req_ready_o SHALL equal !full; no push-bypass when full even if pop same cycle.
REQ-020 Push (req_valid_i & req_ready_o) SHALL write entry at wr_ptr; entry visible at head no earlier than next cycle.
REQ-021 Push with req_need_linefill_i SHALL set inflight[req_lf_id_i] next cycle; biu_rvalid_i SHALL clear inflight[biu_rid_i] next cycle.
REQ-022 Set and clear of same id in same cycle: set SHALL win.
REQ-023 Head SHALL be blocked when its linefill bit is 1 and inflight[lf_id] is 1 (registered value; clear takes effect one cycle later).
REQ-024 isu_sc_valid_o SHALL = !empty & !blocked & credit[head ch] != 0; payload driven from head entry registers.
REQ-025 Issue (isu_sc_valid_o & isu_sc_ready_i) SHALL advance rd_ptr, decrement credit[ch], increment rob_id[ch] modulo 2^ROB_W.
REQ-026 isu_sc_rob_id_o SHALL show current rob_id[head ch] prior to increment.
REQ-027 Credit return on channel with simultaneous issue on same channel SHALL leave credit unchanged.
REQ-028 Credit return when credit == CREDIT_INIT (and no issue) SHALL hold credit and set credit_err_o until reset.
REQ-029 head ch >= NUM_CH SHALL be treated as credit 0 (never issues).
REQ-030 Strict in-order issue: a blocked head SHALL stall all younger entries.
REQ-031 iq_count_o SHALL equal wr_ptr - rd_ptr; simultaneous push and pop SHALL keep count.

Reset
REQ-032 On rst_i: pointers 0, count 0, req_ready_o 1, isu_sc_valid_o 0, inflight all 0, credits CREDIT_INIT, rob ids 0, credit_err_o 0.
REQ-033 Reset mid-operation SHALL discard all entries and in-flight state in one cycle; later BIU returns for stale ids SHALL only clear bits.

Verification
REQ-034 Push 8 non-linefill ch0 requests, sc_ready=1, no credit return -> 4 issue with rob ids 0..3, then valid=0, count=4.
REQ-035 Push ch1 req need_linefill lf_id=0x15 -> valid stays 0; biu_rvalid rid=0x15 at cycle T -> valid=1 at T+1.
REQ-036 Fill DEPTH=8 with sc_ready=0 -> req_ready_o=0 at count 8; push attempt ignored; one pop -> ready=1 next cycle.
REQ-037 Credit return ch2 at CREDIT_INIT -> credit_err_o=1, credit remains 4; issue+return same cycle on ch0 -> credit unchanged.
REQ-038 Issue 9 ch0 requests with credit returns -> rob ids 0..7,0; assert rst_i mid-stream -> count 0, valid 0 next cycle.
